ps2_kbd_tx: RTL

Device-side PS/2 keyboard transmitter: turns one key event (scancode plus extended/release flags) into the corresponding PS/2 byte sequence (`E0`, `F0`, code) and drives it onto self-generated `ps2_clk`/`ps2_data` lines as standard 11-bit frames. It is the keyboard end of the link our `ps2_keyboard` receiver listens to. Uses: keyboard emulation on-board, and loopback stimulus for the receiver/decoder chain.

---
 rtl/ps2_kbd_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: one key event becomes E0/F0/code
// bytes, each sent as an 11-bit frame on self-generated ps2_clk/ps2_data.
module ps2_kbd_tx #(
  parameter int HALF = 2500,
  parameter int GAP  = 5000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_release,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int MAXP = (HALF > GAP) ? HALF : GAP;
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BIT_HI, S_BIT_LO, S_GAP} state_t;

  // Byte slots: 0 = E0 prefix, 1 = F0 prefix, 2 = scancode.
  localparam logic [1:0] SLOT_E0   = 2'd0;
  localparam logic [1:0] SLOT_F0   = 2'd1;
  localparam logic [1:0] SLOT_CODE = 2'd2;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_bit;
  logic [1:0]  r_byte;
  logic [7:0]  r_code;
  logic        r_rel;
  logic        r_clk;
  logic        r_data;
  logic        r_ready;

  logic [7:0]  w_cur;
  logic [1:0]  w_next;
  logic [1:0]  w_first;
  logic        w_half_end;
  logic        w_gap_end;

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
    logic [3:0] w_di;
    w_di = i - 4'd1;
    case (i)
      4'd0:    return 1'b0;
      4'd9:    return ~^b;
      4'd10:   return 1'b1;
      default: return b[w_di[2:0]];
    endcase
  endfunction

  always_comb begin
    w_cur = r_code;
    case (r_byte)
      SLOT_E0: w_cur = 8'hE0;
      SLOT_F0: w_cur = 8'hF0;
      default: w_cur = r_code;
    endcase
    w_next  = (r_byte == SLOT_E0 && r_rel) ? SLOT_F0 : SLOT_CODE;
    w_first = key_ext ? SLOT_E0 : (key_release ? SLOT_F0 : SLOT_CODE);
  end

  assign w_half_end = (r_cnt == CW'(HALF - 1));
  assign w_gap_end  = (r_cnt == CW'(GAP - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_code  <= '0;
      r_rel   <= 1'b0;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid && r_ready) begin
            r_code  <= key_code;
            r_rel   <= key_release;
            r_byte  <= w_first;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_clk   <= 1'b1;
            r_data  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_BIT_HI;
          end
        end
        S_BIT_HI: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_state <= S_BIT_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BIT_LO: begin
          if (w_half_end) begin
            r_cnt <= '0;
            r_clk <= 1'b1;
            if (r_bit < 4'd10) begin
              // Data only moves on BIT_HI entry, a full half-period ahead of the falling edge.
              r_bit   <= r_bit + 4'd1;
              r_data  <= frame_bit(w_cur, r_bit + 4'd1);
              r_state <= S_BIT_HI;
            end else begin
              r_data  <= 1'b1;
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt <= '0;
            if (r_byte != SLOT_CODE) begin
              r_byte  <= w_next;
              r_bit   <= '0;
              r_data  <= 1'b0;
              r_state <= S_BIT_HI;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk   = r_clk;
  assign ps2_data  = r_data;
  assign key_ready = r_ready;
  assign busy      = ~r_ready;

endmodule
